// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM states, baud divider table and frame constants.
package uart_pkg;

  localparam int unsigned DataBits      = 8;
  localparam int unsigned SamplesPerBit = 16;
  localparam int unsigned BaudCntW      = 14;

  localparam logic [3:0] SampleMid  = 4'd8;
  localparam logic [3:0] SampleLast = 4'(SamplesPerBit - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Divider reload value; tick period is baud_max + 1 clocks (16x the bit rate).
  function automatic logic [BaudCntW-1:0] baud_max(input logic [2:0] sel);
    case (sel)
      3'b000:  return 14'd10417;
      3'b001:  return 14'd2604;
      3'b010:  return 14'd651;
      3'b011:  return 14'd326;
      3'b100:  return 14'd163;
      3'b101:  return 14'd81;
      3'b110:  return 14'd54;
      default: return 14'd27;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator: down-counter reloading from the baud table at zero.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic       give_clk,
  input  logic       give_reset,
  input  logic [2:0] baud_select,
  output logic       tick
);

  logic [BaudCntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == '0);

  // baud_select is only looked at on reload, so a change never truncates a period.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (tick) begin
      cnt_d = baud_max(baud_select);
    end
  end

  always_ff @(posedge give_clk or negedge give_reset) begin
    if (!give_reset) begin
      cnt_q <= baud_max(baud_select);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver for start + 8 data (LSB first) + even parity + stop frames, 16x oversampled.
// Define UART_RX_MAJORITY_EN to vote each bit over samples 7, 8 and 9.
module uart_receiver
  import uart_pkg::*;
(
  input  logic       give_clk,
  input  logic       give_reset,
  input  logic [2:0] baud_select,
  input  logic       RX_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  logic                tick;
  logic [1:0]          rxd_sync_q;
  logic                rxd_s;
  rx_state_e           state_q, state_d;
  logic [3:0]          samp_q, samp_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [DataBits-1:0] shreg_q, shreg_d;
  logic                par_q, par_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                perror_q, perror_d;
  logic                ferror_q, ferror_d;
  logic                decide;
  logic                bit_val;

  uart_baud_tick u_baud_tick (
    .give_clk    (give_clk),
    .give_reset  (give_reset),
    .baud_select (baud_select),
    .tick        (tick)
  );

  // RxD is asynchronous to give_clk.
  always_ff @(posedge give_clk or negedge give_reset) begin
    if (!give_reset) begin
      rxd_sync_q <= 2'b11;
    end else begin
      rxd_sync_q <= {rxd_sync_q[0], RxD};
    end
  end

  assign rxd_s = rxd_sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;  // samples 7 and 8 of the current bit

  always_comb begin
    hist_d = hist_q;
    if (tick && (samp_q == SampleMid - 4'd1 || samp_q == SampleMid)) begin
      hist_d = {hist_q[0], rxd_s};
    end
  end

  always_ff @(posedge give_clk or negedge give_reset) begin
    if (!give_reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign decide  = tick && (samp_q == SampleMid + 4'd1);
  assign bit_val = (hist_q[1] & hist_q[0]) | ((hist_q[1] | hist_q[0]) & rxd_s);
`else
  assign decide  = tick && (samp_q == SampleMid);
  assign bit_val = rxd_s;
`endif

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    data_d    = data_q;
    perror_d  = perror_q;
    ferror_d  = ferror_q;
    valid_d   = 1'b0;

    if (!RX_EN) begin
      state_d   = StIdle;
      samp_d    = '0;
      bit_idx_d = '0;
    end else if (tick) begin
      samp_d = samp_q + 1'b1;
      case (state_q)
        StIdle: begin
          samp_d    = '0;
          bit_idx_d = '0;
          if (!rxd_s) begin
            state_d = StStart;
          end
        end
        StStart: begin
          if (decide && bit_val) begin
            state_d = StIdle;
            samp_d  = '0;
          end else if (samp_q == SampleLast) begin
            state_d = StData;
          end
        end
        StData: begin
          if (decide) begin
            shreg_d[bit_idx_q] = bit_val;
          end
          if (samp_q == SampleLast) begin
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == 3'(DataBits - 1)) begin
              state_d = StParity;
            end
          end
        end
        StParity: begin
          if (decide) begin
            par_d = bit_val;
          end
          if (samp_q == SampleLast) begin
            state_d = StStop;
          end
        end
        StStop: begin
          // Finish at mid-stop so the next start edge is seen with half a bit to spare.
          if (decide) begin
            data_d   = shreg_q;
            perror_d = (par_q != ^shreg_q);
            ferror_d = !bit_val;
            valid_d  = (par_q == ^shreg_q) && bit_val;
            state_d  = StIdle;
            samp_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          samp_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge give_clk or negedge give_reset) begin
    if (!give_reset) begin
      state_q   <= StIdle;
      samp_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      perror_q  <= 1'b0;
      ferror_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perror_q  <= perror_d;
      ferror_q  <= ferror_d;
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perror_q;
  assign Rx_FERROR = ferror_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed corner frames plus random frames vs a frame model.
module tb_uart_receiver;

  localparam int TickClks = 28;
  localparam int BitClks  = 16 * TickClks;

  logic       give_clk = 1'b0;
  logic       give_reset = 1'b0;
  logic [2:0] baud_select = 3'b111;
  logic       RX_EN = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;

  // Model of the held outputs: what the last completed frame should have left behind.
  logic [7:0] exp_data = 8'h00;
  logic       exp_pe = 1'b0;
  logic       exp_fe = 1'b0;

  uart_receiver dut (
    .give_clk    (give_clk),
    .give_reset  (give_reset),
    .baud_select (baud_select),
    .RX_EN       (RX_EN),
    .RxD         (RxD),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_PERROR   (Rx_PERROR),
    .Rx_FERROR   (Rx_FERROR)
  );

  always #5 give_clk = ~give_clk;

  always @(negedge give_clk) begin
    if (Rx_VALID === 1'b1) valid_cycles++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".data"}, {24'd0, Rx_DATA}, {24'd0, exp_data});
    check_eq({tag, ".perror"}, {31'd0, Rx_PERROR}, {31'd0, exp_pe});
    check_eq({tag, ".ferror"}, {31'd0, Rx_FERROR}, {31'd0, exp_fe});
  endtask

  task automatic idle(input int n);
    RxD = 1'b1;
    repeat (n) @(posedge give_clk);
  endtask

  // Drives one frame bit-by-bit; abort_at > 0 stops after that many clocks.
  task automatic drive_frame(input logic [7:0] d, input logic p, input logic s, input int abort_at);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11 * BitClks; i++) begin
      if (abort_at > 0 && i == abort_at) return;
      @(posedge give_clk);
      #1;
      RxD = bits[i / BitClks];
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic p, input logic s);
    int  v0;
    logic pe;
    logic fe;
    v0 = valid_cycles;
    drive_frame(d, p, s, 0);
    idle(BitClks);
    pe = (p != ^d);
    fe = !s;
    exp_data = d;
    exp_pe   = pe;
    exp_fe   = fe;
    check_eq({tag, ".valid"}, valid_cycles - v0, (pe || fe) ? 0 : 1);
    check_outputs(tag);
  endtask

  initial begin
    int v0;
    logic [7:0] d;
    logic p;
    logic s;

    repeat (3) @(posedge give_clk);
    #1;
    check_eq("reset.valid", {31'd0, Rx_VALID}, 0);
    check_outputs("reset");
    give_reset = 1'b1;
    idle(BitClks);

    run_frame("a5_ok", 8'hA5, 1'b0, 1'b1);
    run_frame("5a_parity", 8'h5A, 1'b1, 1'b1);
    run_frame("3c_stop0", 8'h3C, 1'b0, 1'b0);
    run_frame("81_after_ferr", 8'h81, 1'b0, 1'b1);

    // Glitch shorter than half a bit must be rejected as a false start.
    v0 = valid_cycles;
    RxD = 1'b0;
    repeat (3 * TickClks) @(posedge give_clk);
    idle(2 * BitClks);
    check_eq("false_start.valid", valid_cycles - v0, 0);
    check_outputs("false_start");

    // Reset in the middle of data bit 4.
    v0 = valid_cycles;
    drive_frame(8'hFF, 1'b0, 1'b1, 5 * BitClks + BitClks / 2);
    #2;
    give_reset = 1'b0;
    RxD = 1'b1;
    #1;
    exp_data = 8'h00;
    exp_pe   = 1'b0;
    exp_fe   = 1'b0;
    check_eq("mid_reset.valid_now", {31'd0, Rx_VALID}, 0);
    check_outputs("mid_reset");
    repeat (5) @(posedge give_clk);
    #1;
    give_reset = 1'b1;
    idle(BitClks);
    check_eq("mid_reset.no_pulse", valid_cycles - v0, 0);
    run_frame("0f_after_reset", 8'h0F, 1'b0, 1'b1);

    // Enable dropped for 2 clocks in the middle of data bit 3; the rest of the line stays high.
    v0 = valid_cycles;
    fork
      drive_frame(8'hF8, 1'b1, 1'b1, 0);
      begin
        repeat (4 * BitClks + BitClks / 2) @(posedge give_clk);
        #1;
        RX_EN = 1'b0;
        repeat (2) @(posedge give_clk);
        #1;
        RX_EN = 1'b1;
      end
    join
    idle(BitClks);
    check_eq("rx_en_abort.valid", valid_cycles - v0, 0);
    check_outputs("rx_en_abort");
    run_frame("55_after_abort", 8'h55, 1'b0, 1'b1);

    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rand%0d", k), d, p, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
